// File: rtl/mem_port_ctrl.sv
// Memory-port sequencer: latches a CPU request, runs the mem_read/mem_write/mem_resp handshake, returns a one-cycle cpu_resp.
// Optional REQ timeout abort is compiled in with `define MEM_TIMEOUT_EN.
module mem_port_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [1:0]  cpu_byte_req,
  input  logic [2:0]  cpu_funct3,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_resp,
  output logic [31:0] cpu_rdata,
  output logic        busy,
  output logic        timeout_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_enable,
  input  logic        mem_resp,
  input  logic [31:0] mem_rdata
);

  // state  | meaning
  // S_IDLE | waiting for cpu_read/cpu_write
  // S_REQ  | strobe held to memory until mem_resp (or timeout)
  // S_DONE | cpu_resp pulse, then back to idle
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t      r_state;
  logic [3:0]  w_be;
  logic        w_unused_addr;

  assign w_unused_addr = ^cpu_addr[1:0];

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^(CNT_W'(TIMEOUT_CYCLES));
  assign timeout_err  = 1'b0;
`endif

  // Lane enables are resolved at request time so they are fixed for the whole REQ phase.
  always_comb begin
    w_be = 4'b1111;
    if (!cpu_read) begin
      case (cpu_funct3)
        3'b000:  w_be = 4'b0001 << cpu_byte_req;
        3'b001:  w_be = cpu_byte_req[1] ? 4'b1100 : 4'b0011;
        default: w_be = 4'b1111;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      cpu_resp        <= 1'b0;
      cpu_rdata       <= '0;
      busy            <= 1'b0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
`ifdef MEM_TIMEOUT_EN
      r_cnt           <= '0;
      timeout_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_read || cpu_write) begin
            mem_address     <= {cpu_addr[31:2], 2'b00};
            mem_wdata       <= cpu_wdata;
            mem_byte_enable <= w_be;
            mem_read        <= cpu_read;
            mem_write       <= ~cpu_read;
            busy            <= 1'b1;
            r_state         <= S_REQ;
`ifdef MEM_TIMEOUT_EN
            r_cnt           <= '0;
`endif
          end
        end
        S_REQ: begin
          if (mem_resp) begin
            if (mem_read) cpu_rdata <= mem_rdata;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            cpu_resp  <= 1'b1;
            r_state   <= S_DONE;
          end
`ifdef MEM_TIMEOUT_EN
          // This REQ cycle is the last one allowed; mem_resp above takes priority.
          else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            cpu_resp    <= 1'b1;
            timeout_err <= 1'b1;
            cpu_rdata   <= '0;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          cpu_resp <= 1'b0;
          busy     <= 1'b0;
          r_state  <= S_IDLE;
`ifdef MEM_TIMEOUT_EN
          timeout_err <= 1'b0;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
